// File: rtl/clause_bin_loader_if.sv
// Purpose : bundles the clause-memory bus, clause_array slot bus and start/status
//           handshake of clause_bin_loader into one port.
// Ports   : master = loader side (drives strobes/addr/data, sees starts and read data);
//           slave  = environment side (memory + clause_array + controller).
interface clause_bin_loader_if #(
   parameter int NUM_CLAUSES = 8,
   parameter int NUM_VARS    = 8,
   parameter int WIDTH_C_LEN = 4,
   parameter int WIDTH_ADDR  = 16
);
   localparam int CW = NUM_VARS * 2;
   localparam int DW = WIDTH_C_LEN + CW;

   logic                   start_load_i;
   logic                   start_update_i;
   logic [WIDTH_ADDR-1:0]  base_addr_i;
   logic                   mem_rd_o;
   logic                   mem_wr_o;
   logic [WIDTH_ADDR-1:0]  mem_addr_o;
   logic [DW-1:0]          mem_rdata_i;
   logic [DW-1:0]          mem_wdata_o;
   logic [NUM_CLAUSES-1:0] wr_o;
   logic [NUM_CLAUSES-1:0] rd_o;
   logic [CW-1:0]          clause_o;
   logic [WIDTH_C_LEN-1:0] clause_len_o;
   logic [CW-1:0]          clause_i;
   logic                   busy_o;
   logic                   done_o;

   modport master (
      input  start_load_i, start_update_i, base_addr_i, mem_rdata_i, clause_i,
      output mem_rd_o, mem_wr_o, mem_addr_o, mem_wdata_o, wr_o, rd_o,
             clause_o, clause_len_o, busy_o, done_o
   );

   modport slave (
      output start_load_i, start_update_i, base_addr_i, mem_rdata_i, clause_i,
      input  mem_rd_o, mem_wr_o, mem_addr_o, mem_wdata_o, wr_o, rd_o,
             clause_o, clause_len_o, busy_o, done_o
   );
endinterface

// File: rtl/clause_bin_loader.sv
// Purpose : streams one bin of clauses memory -> clause_array (load) or array -> memory
//           (update), keeping a local copy of each clause length for write-back.
// Latency : first strobe the cycle after an accepted start; done_o NUM_CLAUSES+1 cycles later.
// Flow    : no backpressure; one slot per cycle. Starts outside IDLE are dropped.
// Ports   : clk, rst (async, active-high); bus = clause_bin_loader_if.master.
module clause_bin_loader #(
   parameter int NUM_CLAUSES = 8,
   parameter int NUM_VARS    = 8,
   parameter int WIDTH_C_LEN = 4,
   parameter int WIDTH_ADDR  = 16
) (
   input logic                clk,
   input logic                rst,
   clause_bin_loader_if.master bus
);
   localparam int CW   = NUM_VARS * 2;
   localparam int DW   = WIDTH_C_LEN + CW;
   localparam int IW   = $clog2(NUM_CLAUSES);
   localparam int CNTW = $clog2(NUM_CLAUSES + 1);

   localparam logic [CNTW-1:0]        CNT_LAST = CNTW'(NUM_CLAUSES - 1);
   localparam logic [CNTW-1:0]        CNT_END  = CNTW'(NUM_CLAUSES);
   localparam logic [NUM_CLAUSES-1:0] ONE      = NUM_CLAUSES'(1);

   typedef enum logic [1:0] {IDLE, LOAD, UPDATE, DONE} state_t;

   state_t                 state, state_n;
   logic [CNTW-1:0]        idx, idx_n;     // slot whose read was issued in the current cycle
   logic [WIDTH_ADDR-1:0]  base, base_n;
   logic [WIDTH_C_LEN-1:0] len_reg [NUM_CLAUSES];
   logic                   len_we;
   logic [IW-1:0]          len_sel;

   // Registered copies of every output, plus their next values.
   logic                   mem_rd_q, mem_rd_n, mem_wr_q, mem_wr_n;
   logic [WIDTH_ADDR-1:0]  addr_q, addr_n;
   logic [DW-1:0]          wdata_q, wdata_n;
   logic [NUM_CLAUSES-1:0] wr_q, wr_n, rd_q, rd_n;
   logic [CW-1:0]          clause_q, clause_n;
   logic [WIDTH_C_LEN-1:0] len_q, len_n;
   logic                   busy_q, busy_n, done_q, done_n;

   always_comb begin
      state_n  = state;
      idx_n    = idx;
      base_n   = base;
      mem_rd_n = 1'b0;
      mem_wr_n = 1'b0;
      addr_n   = addr_q;
      wdata_n  = wdata_q;
      wr_n     = '0;
      rd_n     = '0;
      clause_n = clause_q;
      len_n    = len_q;
      busy_n   = 1'b0;
      done_n   = 1'b0;
      len_we   = 1'b0;
      len_sel  = idx[IW-1:0];

      case (state)
         IDLE: begin
            // Load has priority when both starts arrive together.
            if (bus.start_load_i) begin
               state_n  = LOAD;
               base_n   = bus.base_addr_i;
               idx_n    = '0;
               mem_rd_n = 1'b1;
               addr_n   = bus.base_addr_i;
               busy_n   = 1'b1;
            end else if (bus.start_update_i) begin
               state_n = UPDATE;
               base_n  = bus.base_addr_i;
               idx_n   = '0;
               rd_n    = ONE;
               busy_n  = 1'b1;
            end
         end
         LOAD: begin
            idx_n  = idx + CNTW'(1);
            busy_n = 1'b1;
            if (idx == CNT_END) begin
               state_n = DONE;
               busy_n  = 1'b0;
               done_n  = 1'b1;
            end else begin
               // Memory data for slot idx is present now; write it to the array next cycle
               // while the read for slot idx+1 goes out alongside it.
               wr_n     = ONE << idx;
               clause_n = bus.mem_rdata_i[CW-1:0];
               len_n    = bus.mem_rdata_i[DW-1:CW];
               len_we   = 1'b1;
               if (idx != CNT_LAST) begin
                  mem_rd_n = 1'b1;
                  addr_n   = base + WIDTH_ADDR'(idx) + WIDTH_ADDR'(1);
               end
            end
         end
         UPDATE: begin
            idx_n  = idx + CNTW'(1);
            busy_n = 1'b1;
            if (idx == CNT_END) begin
               state_n = DONE;
               busy_n  = 1'b0;
               done_n  = 1'b1;
            end else begin
               mem_wr_n = 1'b1;
               addr_n   = base + WIDTH_ADDR'(idx);
               wdata_n  = {len_reg[len_sel], bus.clause_i};
               if (idx != CNT_LAST) begin
                  rd_n = ONE << (idx + CNTW'(1));
               end
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         idx      <= '0;
         base     <= '0;
         mem_rd_q <= 1'b0;
         mem_wr_q <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wr_q     <= '0;
         rd_q     <= '0;
         clause_q <= '0;
         len_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         for (int i = 0; i < NUM_CLAUSES; i++) begin
            len_reg[i] <= '0;
         end
      end else begin
         state    <= state_n;
         idx      <= idx_n;
         base     <= base_n;
         mem_rd_q <= mem_rd_n;
         mem_wr_q <= mem_wr_n;
         addr_q   <= addr_n;
         wdata_q  <= wdata_n;
         wr_q     <= wr_n;
         rd_q     <= rd_n;
         clause_q <= clause_n;
         len_q    <= len_n;
         busy_q   <= busy_n;
         done_q   <= done_n;
         if (len_we) begin
            len_reg[len_sel] <= len_n;
         end
      end
   end

   assign bus.mem_rd_o     = mem_rd_q;
   assign bus.mem_wr_o     = mem_wr_q;
   assign bus.mem_addr_o   = addr_q;
   assign bus.mem_wdata_o  = wdata_q;
   assign bus.wr_o         = wr_q;
   assign bus.rd_o         = rd_q;
   assign bus.clause_o     = clause_q;
   assign bus.clause_len_o = len_q;
   assign bus.busy_o       = busy_q;
   assign bus.done_o       = done_q;
endmodule

// File: tb/tb_clause_bin_loader.sv
// Directed bench for clause_bin_loader: reset, load, update, address wrap,
// start arbitration/ignoring, back-to-back starts and mid-load reset abort.
module tb_clause_bin_loader;
   localparam int N = 8;
   localparam int V = 8;
   localparam int L = 4;
   localparam int A = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   clause_bin_loader_if #(.NUM_CLAUSES(N), .NUM_VARS(V), .WIDTH_C_LEN(L), .WIDTH_ADDR(A)) bus ();

   clause_bin_loader #(.NUM_CLAUSES(N), .NUM_VARS(V), .WIDTH_C_LEN(L), .WIDTH_ADDR(A)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // External clause memory: data for the address being read is presented in the read cycle.
   logic [19:0] mem [0:65535];
   always_comb bus.mem_rdata_i = bus.mem_rd_o ? mem[bus.mem_addr_o] : 20'h0;

   // clause_array stand-in: slot k returns 16'hA5A5 ^ k.
   always_comb begin
      bus.clause_i = 16'h0;
      for (int i = 0; i < N; i++) begin
         if (bus.rd_o[i]) bus.clause_i = 16'hA5A5 ^ 16'(i);
      end
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " mem_rd"}, 32'(bus.mem_rd_o), 32'h0);
      chk({tag, " mem_wr"}, 32'(bus.mem_wr_o), 32'h0);
      chk({tag, " wr"},     32'(bus.wr_o),     32'h0);
      chk({tag, " rd"},     32'(bus.rd_o),     32'h0);
      chk({tag, " busy"},   32'(bus.busy_o),   32'h0);
      chk({tag, " done"},   32'(bus.done_o),   32'h0);
   endtask

   task automatic start_op(input logic ld, input logic up, input logic [15:0] base);
      bus.start_load_i   = ld;
      bus.start_update_i = up;
      bus.base_addr_i    = base;
      tick();
      bus.start_load_i   = 1'b0;
      bus.start_update_i = 1'b0;
      bus.base_addr_i    = 16'h0;
   endtask

   // Walks cycles 0..N+1 after an accepted load. patc selects the wrap-test memory pattern
   // ({C, addr}); otherwise {k+1, 16'h0101<<k}. noise pulses both starts at cycle 3.
   // abort_at >= 0 asserts reset at that cycle and checks the abort.
   task automatic check_load(input logic [15:0] base, input bit patc, input bit noise,
                             input int abort_at);
      logic [15:0] e_clause;
      logic [3:0]  e_len;
      logic [7:0]  e_wr;
      int          k;
      for (int j = 0; j <= N + 1; j++) begin
         chk($sformatf("ld mem_rd j=%0d", j), 32'(bus.mem_rd_o), (j < N) ? 32'h1 : 32'h0);
         if (j < N) chk($sformatf("ld addr j=%0d", j), 32'(bus.mem_addr_o), 32'(16'(base + 16'(j))));
         chk($sformatf("ld mem_wr j=%0d", j), 32'(bus.mem_wr_o), 32'h0);
         chk($sformatf("ld rd j=%0d", j), 32'(bus.rd_o), 32'h0);
         e_wr = 8'h0;
         if (j >= 1 && j <= N) begin
            k    = j - 1;
            e_wr = 8'h01 << k;
            if (patc) begin
               e_clause = 16'(base + 16'(k));
               e_len    = 4'hC;
            end else begin
               e_clause = 16'h0101 << k;
               e_len    = 4'(k + 1);
            end
            chk($sformatf("ld clause j=%0d", j), 32'(bus.clause_o), 32'(e_clause));
            chk($sformatf("ld len j=%0d", j), 32'(bus.clause_len_o), 32'(e_len));
         end
         chk($sformatf("ld wr j=%0d", j), 32'(bus.wr_o), 32'(e_wr));
         chk($sformatf("ld busy j=%0d", j), 32'(bus.busy_o), (j <= N) ? 32'h1 : 32'h0);
         chk($sformatf("ld done j=%0d", j), 32'(bus.done_o), (j == N + 1) ? 32'h1 : 32'h0);
         if (j == abort_at) begin
            rst = 1'b1;
            tick();
            chk_idle("abort");
            rst = 1'b0;
            repeat (4) begin
               tick();
               chk_idle("post-abort");
            end
            return;
         end
         if (j <= N) begin
            if (noise && j == 3) begin
               bus.start_load_i   = 1'b1;
               bus.start_update_i = 1'b1;
               bus.base_addr_i    = 16'h1234;
            end
            tick();
            bus.start_load_i   = 1'b0;
            bus.start_update_i = 1'b0;
            bus.base_addr_i    = 16'h0;
         end
      end
   endtask

   // Walks cycles 0..N+1 after an accepted update; lengths expected from the earlier load.
   task automatic check_update(input logic [15:0] base);
      logic [19:0] e_wdata;
      logic [7:0]  e_rd;
      int          k;
      for (int j = 0; j <= N + 1; j++) begin
         e_rd = 8'h0;
         if (j < N) e_rd = 8'h01 << j;
         chk($sformatf("up rd j=%0d", j), 32'(bus.rd_o), 32'(e_rd));
         chk($sformatf("up mem_wr j=%0d", j), 32'(bus.mem_wr_o), (j >= 1 && j <= N) ? 32'h1 : 32'h0);
         chk($sformatf("up mem_rd j=%0d", j), 32'(bus.mem_rd_o), 32'h0);
         chk($sformatf("up wr j=%0d", j), 32'(bus.wr_o), 32'h0);
         if (j >= 1 && j <= N) begin
            k       = j - 1;
            e_wdata = {4'(k + 1), 16'hA5A5 ^ 16'(k)};
            chk($sformatf("up addr j=%0d", j), 32'(bus.mem_addr_o), 32'(16'(base + 16'(k))));
            chk($sformatf("up wdata j=%0d", j), 32'(bus.mem_wdata_o), 32'(e_wdata));
         end
         chk($sformatf("up busy j=%0d", j), 32'(bus.busy_o), (j <= N) ? 32'h1 : 32'h0);
         chk($sformatf("up done j=%0d", j), 32'(bus.done_o), (j == N + 1) ? 32'h1 : 32'h0);
         if (j <= N) tick();
      end
   endtask

   initial begin
      logic [15:0] a;
      for (int k = 0; k < N; k++) begin
         mem[16'h0010 + 16'(k)] = {4'(k + 1), 16'h0101 << k};
         a = 16'hFFFE + 16'(k);
         mem[a] = {4'hC, a};
      end

      rst                = 1'b1;
      bus.start_load_i   = 1'b0;
      bus.start_update_i = 1'b0;
      bus.base_addr_i    = 16'h0;
      repeat (2) tick();
      chk_idle("reset");
      chk("reset addr", 32'(bus.mem_addr_o), 32'h0);
      chk("reset clause", 32'(bus.clause_o), 32'h0);
      rst = 1'b0;
      tick();
      chk_idle("after reset");

      // Load bin at 0x0010, then a start_load in the done cycle must be ignored.
      start_op(1'b1, 1'b0, 16'h0010);
      check_load(16'h0010, 1'b0, 1'b0, -1);
      bus.start_load_i = 1'b1;
      bus.base_addr_i  = 16'h0040;
      tick();
      bus.start_load_i = 1'b0;
      bus.base_addr_i  = 16'h0;
      chk_idle("start in done cycle");

      // Update accepted in the cycle right after; write-back uses saved lengths.
      start_op(1'b0, 1'b1, 16'h0010);
      check_update(16'h0010);
      tick();
      chk_idle("after update");

      // Address wrap.
      start_op(1'b1, 1'b0, 16'hFFFE);
      check_load(16'hFFFE, 1'b1, 1'b0, -1);
      tick();
      chk_idle("after wrap");

      // Both starts together -> load only; starts while busy are ignored.
      start_op(1'b1, 1'b1, 16'h0010);
      check_load(16'h0010, 1'b0, 1'b1, -1);
      tick();
      chk_idle("after both-start");
      tick();
      chk_idle("no queued op");

      // Reset mid-load at k=3.
      start_op(1'b1, 1'b0, 16'h0010);
      check_load(16'h0010, 1'b0, 1'b0, 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
